// File: rtl/instr_fetch_unit_if.sv
// Request/write/status bundle between the fetch unit and the decode/execute side.
// master = the side issuing requests and program writes; slave = the fetch unit.
interface instr_fetch_unit_if #(
  parameter int OP_SIZE     = 4,
  parameter int ARG_SIZE    = 3,
  parameter int ARG_NUM     = 2,
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int IW    = OP_SIZE + ARG_NUM * ARG_SIZE;
  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic              branch;
  logic [ADDR_W-1:0] branch_addr;
  logic              call;
  logic              ret;
  logic              done;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [IW-1:0]     prog_data;
  logic [IW-1:0]     instruction;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              stack_err;
  logic [LVL_W-1:0]  stack_level;

  modport master (
    output branch, branch_addr, call, ret, done, prog_we, prog_addr, prog_data,
    input  instruction, pc, halted, stack_err, stack_level
  );

  modport slave (
    input  branch, branch_addr, call, ret, done, prog_we, prog_addr, prog_data,
    output instruction, pc, halted, stack_err, stack_level
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter, writable instruction store and call/return stack with HALT detection.
// Define IFU_RELATIVE_BRANCH_EN to make branch (not call) add a signed offset to pc.
module instr_fetch_unit #(
  parameter int                  OP_SIZE     = 4,
  parameter int                  ARG_SIZE    = 3,
  parameter int                  ARG_NUM     = 2,
  parameter int                  ADDR_W      = 4,
  parameter int                  STACK_DEPTH = 4,
  parameter logic [OP_SIZE-1:0]  OP_HALT     = {OP_SIZE{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.slave  bus
);
  localparam int IW    = OP_SIZE + ARG_NUM * ARG_SIZE;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int LVL_W = SP_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  // One resolved action per edge; lower-priority requests are simply dropped.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_BRANCH,
    ACT_CALL,
    ACT_RET,
    ACT_DONE,
    ACT_ERR
  } act_e;

  // NOTE: the store and the return stack are plain RAM arrays with no reset
  // path; the store only gets a power-up value, and stale stack slots are
  // unreachable because the level counter is what resets.
  logic [IW-1:0]     store [DEPTH] = '{default: '0};
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_target;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              err_q, err_d;
  logic              push;
  logic [SP_W-1:0]   push_idx;
  logic [SP_W-1:0]   pop_idx;
  logic              stack_full;
  logic              stack_empty;
  logic              halted;
  act_e              act;

  assign bus.instruction = store[pc_q];
  assign halted          = (bus.instruction[IW-1 -: OP_SIZE] == OP_HALT);
  assign bus.halted      = halted;
  assign bus.pc          = pc_q;
  assign bus.stack_err   = err_q;
  assign bus.stack_level = level_q;

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign stack_full  = (level_q == LVL_FULL);
  assign stack_empty = (level_q == '0);
  assign push_idx    = level_q[SP_W-1:0];
  assign pop_idx     = push_idx - SP_W'(1);

`ifdef IFU_RELATIVE_BRANCH_EN
  // Two's-complement offset: plain modular addition does the sign handling.
  assign branch_target = pc_q + bus.branch_addr;
`else
  assign branch_target = bus.branch_addr;
`endif

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    act = ACT_HOLD;
    if (bus.branch) begin
      act = ACT_BRANCH;
    end else if (bus.call) begin
      act = stack_full ? ACT_ERR : ACT_CALL;
    end else if (bus.ret) begin
      act = stack_empty ? ACT_ERR : ACT_RET;
    end else if (bus.done && !halted) begin
      act = ACT_DONE;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    level_d = level_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (act)
      ACT_BRANCH: pc_d = branch_target;
      ACT_CALL: begin
        push    = 1'b1;
        level_d = level_q + LVL_W'(1);
        pc_d    = bus.branch_addr;
      end
      ACT_RET: begin
        level_d = level_q - LVL_W'(1);
        pc_d    = stack[pop_idx];
      end
      ACT_DONE: pc_d  = pc_inc;
      ACT_ERR:  err_d = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack[push_idx] <= pc_inc;
    end
  end

  // Program writes ignore rst and PC activity; a write to pc shows next cycle.
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      store[bus.prog_addr] <= bus.prog_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a queue/array reference model checked every
// cycle, plus literal expectations taken from the fetch/call/halt scenarios.
module tb_instr_fetch_unit;
  localparam int OP_SIZE     = 4;
  localparam int ARG_SIZE    = 3;
  localparam int ARG_NUM     = 2;
  localparam int ADDR_W      = 4;
  localparam int STACK_DEPTH = 4;
  localparam int IW          = OP_SIZE + ARG_NUM * ARG_SIZE;
  localparam int DEPTH       = 2 ** ADDR_W;
  localparam logic [OP_SIZE-1:0] OP_HALT = 4'b1111;

  localparam logic [IW-1:0] W_A    = 10'h041;
  localparam logic [IW-1:0] W_B    = 10'h0A2;
  localparam logic [IW-1:0] W_C    = 10'h113;
  localparam logic [IW-1:0] W_D    = 10'h184;
  localparam logic [IW-1:0] W_X    = 10'h2A5;
  localparam logic [IW-1:0] W_HALT = {OP_HALT, 6'b0};

  logic clk = 1'b0;
  logic rst;

  instr_fetch_unit_if #(
    .OP_SIZE(OP_SIZE), .ARG_SIZE(ARG_SIZE), .ARG_NUM(ARG_NUM),
    .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)
  ) bus ();

  instr_fetch_unit #(
    .OP_SIZE(OP_SIZE), .ARG_SIZE(ARG_SIZE), .ARG_NUM(ARG_NUM),
    .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .OP_HALT(OP_HALT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: pc as an integer, return stack as a queue, store as an array.
  int            m_pc;
  int            m_stk[$];
  bit            m_err;
  logic [IW-1:0] m_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pc",     32'(bus.pc),          32'(m_pc));
      check("cyc_instr",  32'(bus.instruction), 32'(m_mem[m_pc]));
      check("cyc_halted", 32'(bus.halted),      32'(m_mem[m_pc][IW-1 -: OP_SIZE] == OP_HALT));
      check("cyc_err",    32'(bus.stack_err),   32'(m_err));
      check("cyc_level",  32'(bus.stack_level), 32'(m_stk.size()));
    end
  end

  task automatic model_update();
    bit hlt;
    int off;
    hlt = (m_mem[m_pc][IW-1 -: OP_SIZE] == OP_HALT);
    if (rst) begin
      m_pc = 0;
      m_stk.delete();
      m_err = 1'b0;
    end else if (bus.branch) begin
`ifdef IFU_RELATIVE_BRANCH_EN
      off  = bus.branch_addr[ADDR_W-1] ? int'(bus.branch_addr) - DEPTH : int'(bus.branch_addr);
      m_pc = (m_pc + off) & (DEPTH - 1);
`else
      off  = 0;
      m_pc = int'(bus.branch_addr);
`endif
    end else if (bus.call) begin
      if (m_stk.size() < STACK_DEPTH) begin
        m_stk.push_back((m_pc + 1) % DEPTH);
        m_pc = int'(bus.branch_addr);
      end else begin
        m_err = 1'b1;
      end
    end else if (bus.ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else                  m_err = 1'b1;
    end else if (bus.done && !hlt) begin
      m_pc = (m_pc + 1) % DEPTH;
    end
    if (bus.prog_we) m_mem[bus.prog_addr] = bus.prog_data;
  endtask

  task automatic idle();
    rst             = 1'b0;
    bus.branch      = 1'b0;
    bus.branch_addr = '0;
    bus.call        = 1'b0;
    bus.ret         = 1'b0;
    bus.done        = 1'b0;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    idle();
  endtask

  // Branch operand that lands on absolute target t in either branch mode.
  function automatic logic [ADDR_W-1:0] ba_for(input int t);
`ifdef IFU_RELATIVE_BRANCH_EN
    return ADDR_W'(t - m_pc);
`else
    return ADDR_W'(t);
`endif
  endfunction

  task automatic write(input int a, input logic [IW-1:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = ADDR_W'(a); bus.prog_data = d;
    step();
  endtask

  task automatic do_done(input int n);
    repeat (n) begin bus.done = 1'b1; step(); end
  endtask

  task automatic goto(input int t);
    bus.branch = 1'b1; bus.branch_addr = ba_for(t);
    step();
  endtask

  task automatic do_call(input int t);
    bus.call = 1'b1; bus.branch_addr = ADDR_W'(t);
    step();
  endtask

  task automatic do_ret();
    bus.ret = 1'b1;
    step();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
  endtask

  initial begin
    idle();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pc = 0; m_err = 1'b0;

    do_rst();
    chk_en = 1'b1;
    check("rst_pc",    32'(bus.pc), 0);
    check("rst_level", 32'(bus.stack_level), 0);
    check("rst_err",   32'(bus.stack_err), 0);

    // Sequential fetch; the reset cycle also carries a write to store[6].
    write(0, W_A); write(1, W_B); write(2, W_C); write(3, W_D);
    rst = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = 4'd6; bus.prog_data = 10'h155;
    step();
    check("seq_pc0", 32'(bus.pc), 0);
    check("seq_i0",  32'(bus.instruction), 32'(W_A));
    do_done(1); check("seq_i1", 32'(bus.instruction), 32'(W_B));
    do_done(1); check("seq_i2", 32'(bus.instruction), 32'(W_C));
    do_done(1); check("seq_pc3", 32'(bus.pc), 3);
    check("seq_i3", 32'(bus.instruction), 32'(W_D));
    step(); step();
    check("hold_pc", 32'(bus.pc), 3);

    // Wrap and branch-over-done priority.
    goto(15);   check("br_pc15", 32'(bus.pc), 15);
    do_done(1); check("wrap_pc", 32'(bus.pc), 0);
    bus.branch = 1'b1; bus.branch_addr = ba_for(9); bus.done = 1'b1;
    step();     check("br_done_pc", 32'(bus.pc), 9);
    goto(6);    check("rst_write", 32'(bus.instruction), 10'h155);

    // Call / return.
    goto(2);
    do_call(8); check("call_pc", 32'(bus.pc), 8);
    check("call_level", 32'(bus.stack_level), 1);
    do_done(2); check("call_done_pc", 32'(bus.pc), 10);
    do_ret();   check("ret_pc", 32'(bus.pc), 3);
    check("ret_level", 32'(bus.stack_level), 0);
    check("ret_err",   32'(bus.stack_err), 0);
    bus.branch = 1'b1; bus.call = 1'b1; bus.branch_addr = ba_for(7);
    step();     check("br_call_pc", 32'(bus.pc), 7);
    check("br_call_level", 32'(bus.stack_level), 0);

    // Overflow, underflow, sticky error.
    do_call(8); do_call(9); do_call(10); do_call(11);
    check("full_level", 32'(bus.stack_level), 4);
    do_call(12);
    check("ovf_pc",    32'(bus.pc), 11);
    check("ovf_err",   32'(bus.stack_err), 1);
    check("ovf_level", 32'(bus.stack_level), 4);
    do_rst();
    do_ret();
    check("unf_err", 32'(bus.stack_err), 1);
    check("unf_pc",  32'(bus.pc), 0);
    do_done(2); check("sticky_err", 32'(bus.stack_err), 1);
    do_rst();   check("clr_err", 32'(bus.stack_err), 0);

    // HALT stops done; only a branch leaves it.
    write(5, W_HALT);
    do_done(5); check("halt_pc", 32'(bus.pc), 5);
    check("halt_flag", 32'(bus.halted), 1);
    do_done(3); check("halt_hold_pc", 32'(bus.pc), 5);
    goto(0);    check("unhalt_pc", 32'(bus.pc), 0);
    check("unhalt_flag", 32'(bus.halted), 0);

    // Write to the address currently being fetched.
    goto(4);
    bus.prog_we = 1'b1; bus.prog_addr = 4'd4; bus.prog_data = W_X;
    check("wr_old", 32'(bus.instruction), 0);
    step();
    check("wr_new", 32'(bus.instruction), 32'(W_X));

    // Branch operand 4'b1110: offset -2 in relative mode, absolute 14 otherwise.
    goto(6);
    bus.branch = 1'b1; bus.branch_addr = 4'b1110;
    step();
`ifdef IFU_RELATIVE_BRANCH_EN
    check("rel_br_pc", 32'(bus.pc), 4);
`else
    check("abs_br_pc", 32'(bus.pc), 14);
`endif
    do_call(3); check("abs_call_pc", 32'(bus.pc), 3);
    goto(15);
    do_call(2); do_ret();
    check("ret_wrap_pc", 32'(bus.pc), 0);
    check("ret_wrap_level", 32'(bus.stack_level), 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised program-counter and instruction-store block feeding the decode/execute datapath; successor to the fixed 16-entry ROM/PC unit.
- Adds a writable instruction store, configurable depth and width, and a call/return stack.
- Adds HALT detection and sticky error reporting.
- Combinational instruction read from the current PC; all state updates on the rising edge of clk.

Parameters:
- OP_SIZE, 4, opcode field width.
- ARG_SIZE, 3, width of each argument field.
- ARG_NUM, 2, number of argument fields.
- ADDR_W, 4, PC/address width; store depth = 2**ADDR_W.
- STACK_DEPTH, 4, return-stack entries (power of two, >=2).
- OP_HALT, 4'b1111, opcode value that halts fetch.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- branch  in  1  load PC from branch_addr.
- branch_addr  in  ADDR_W  branch target.
- call  in  1  push PC+1 onto the return stack, then jump to branch_addr.
- ret  in  1  pop the return stack into PC.
- done  in  1  execute stage finished current instruction; advance PC.
- prog_we  in  1  instruction-store write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  IW  write data, where IW = OP_SIZE+ARG_NUM*ARG_SIZE.
- instruction  out  IW  store[pc], combinational.
- pc  out  ADDR_W  current program counter.
- halted  out  1  current opcode == OP_HALT.
- stack_err  out  1  sticky overflow/underflow flag.
- stack_level  out  clog2(STACK_DEPTH)+1  occupied entries.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: pc=0, stack_level=0, stack_err=0. Store contents are NOT cleared by rst; the store powers up all-zero via initial block.
- halted is combinational: instruction[IW-1 -: OP_SIZE]==OP_HALT.
- PC update priority per edge: rst > branch > call > ret > done > hold.
  - branch: pc<=branch_addr. Stack unchanged.
  - call, stack not full: stack[level]<=pc+1 (wraps mod 2**ADDR_W); level+1; pc<=branch_addr.
  - call, stack full: no push, pc unchanged, stack_err<=1.
  - ret, stack not empty: level-1; pc<=stack[level-1].
  - ret, stack empty: pc unchanged, stack_err<=1.
  - done while !halted: pc<=pc+1, wrapping 2**ADDR_W-1 -> 0.
  - done while halted: pc holds. Only branch/call/ret/rst leave a HALT.
- Lower-priority requests in the same cycle are dropped, not queued. Example: branch+call -> branch only, no push.
- stack_err clears only on rst.
- Write port:
  - prog_we writes store[prog_addr]<=prog_data at the edge, independent of PC activity.
  - Write to the address equal to pc: instruction shows old data this cycle, new data from the next cycle.
  - rst does not block writes in the same cycle.
- Latency: PC change visible on instruction in the same cycle the new pc appears, i.e. one edge after the request.

Optional Feature:
- Macro: IFU_RELATIVE_BRANCH_EN.
- Defined: branch (not call) treats branch_addr as a signed two's-complement offset; pc<=pc+branch_addr mod 2**ADDR_W. call remains absolute.
- Undefined: branch is absolute as above.

Test Plan:
- Reset/sequential fetch:
  - Program store[0..3]=A,B,C,D via prog_we; assert rst, then done for 3 cycles -> pc 0,1,2,3; instruction A,B,C,D.
  - Hold done low -> pc stays 3.
- Wrap and branch:
  - pc=15 (ADDR_W=4) + done -> pc=0.
  - branch=1, branch_addr=9 with done=1 same cycle -> pc=9 (branch wins).
- Call/return:
  - pc=2, call to 8 -> pc=8, stack_level=1.
  - done x2 -> pc=10; ret -> pc=3, stack_level=0, stack_err=0.
- Stack errors:
  - 5 calls with STACK_DEPTH=4 -> 5th call leaves pc unchanged, stack_err=1, level=4.
  - After rst, ret on empty stack -> stack_err=1, pc=0.
  - stack_err stays 1 until rst.
- HALT:
  - store[5]={OP_HALT,0,0}; reach pc=5 -> halted=1.
  - done for 3 cycles -> pc stays 5.
  - branch to 0 -> halted=0, pc=0.
- Write collision and optional feature:
  - pc=4, prog_we to addr 4 with X -> instruction shows old value that cycle, X next cycle.
  - With IFU_RELATIVE_BRANCH_EN, pc=6, branch_addr=4'b1110 -> pc=4.
